// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded fields into instruction words and streams them into instruction memory
module instruction_encoder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_opcode,
  input  logic [4:0]               in_reg_a,
  input  logic [4:0]               in_reg_b,
  input  logic [4:0]               in_reg_c,
  input  logic [31:0]              in_immediate,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_data,
  input  logic                     mem_ready,
  output logic                     error_pulse,
  output logic                     wrapped,
  output logic [COUNT_WIDTH-1:0]   word_count,
  output logic [COUNT_WIDTH-1:0]   error_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic                     wrapped_q, wrapped_d;
  logic [COUNT_WIDTH-1:0]   word_count_q, word_count_d;
  logic [COUNT_WIDTH-1:0]   error_count_q, error_count_d;

  logic [31:0] word_enc;
  logic        imm_ok;
  logic        fits12, fits16, fits27;

  // A value survives sign extension from N bits when bits [31:N-1] all match.
  assign fits12 = (&in_immediate[31:11]) | ~(|in_immediate[31:11]);
  assign fits16 = (&in_immediate[31:15]) | ~(|in_immediate[31:15]);
  assign fits27 = (&in_immediate[31:26]) | ~(|in_immediate[31:26]);

  always_comb begin
    word_enc        = 32'd0;
    word_enc[31:27] = in_opcode;
    imm_ok          = 1'b1;
    case (in_opcode)
      5'd0, 5'd2: begin
        word_enc[26:22] = in_reg_a;
        word_enc[21:6]  = in_immediate[15:0];
        word_enc[5:1]   = in_reg_b;
        imm_ok          = fits16;
      end
      5'd3, 5'd12: begin
        word_enc[26:22] = in_reg_a;
        word_enc[21:17] = in_reg_b;
        word_enc[16:12] = in_reg_c;
        word_enc[11:0]  = in_immediate[11:0];
        imm_ok          = fits12;
      end
      5'd13, 5'd18: begin
        word_enc[26:0] = in_immediate[26:0];
        imm_ok         = fits27;
      end
      default: begin
        word_enc[26:22] = in_reg_a;
        word_enc[21:17] = in_reg_b;
        word_enc[16:12] = in_reg_c;
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) && !clear;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wrapped_d     = wrapped_q;
    word_count_d  = word_count_q;
    error_count_d = error_count_q;
    if (clear) begin
      state_d       = ST_IDLE;
      addr_d        = '0;
      wrapped_d     = 1'b0;
      word_count_d  = '0;
      error_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (imm_ok) begin
              state_d = ST_WRITE;
              data_d  = word_enc;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            state_d = ST_IDLE;
            addr_d  = addr_q + ADDRESS_WIDTH'(1);
            if (&addr_q) wrapped_d = 1'b1;
            if (!(&word_count_q)) word_count_d = word_count_q + COUNT_WIDTH'(1);
          end
        end
        ST_ERROR: begin
          state_d = ST_IDLE;
          if (!(&error_count_q)) error_count_d = error_count_q + COUNT_WIDTH'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= 32'd0;
      wrapped_q     <= 1'b0;
      word_count_q  <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wrapped_q     <= wrapped_d;
      word_count_q  <= word_count_d;
      error_count_q <= error_count_d;
    end
  end

  // Write enable and error pulse decode straight from the state register.
  assign mem_write_enable = (state_q == ST_WRITE);
  assign error_pulse      = (state_q == ST_ERROR);
  assign mem_address      = addr_q;
  assign mem_data         = data_q;
  assign wrapped          = wrapped_q;
  assign word_count       = word_count_q;
  assign error_count      = error_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

  logic        clock;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [4:0]  in_opcode, in_reg_a, in_reg_b, in_reg_c;
  logic [31:0] in_immediate;
  logic        mem_ready;

  logic        in_ready, mem_write_enable, error_pulse, wrapped;
  logic [3:0]  mem_address;
  logic [31:0] mem_data;
  logic [15:0] word_count, error_count;

  logic        s_in_ready, s_we, s_error_pulse, s_wrapped;
  logic [1:0]  s_address;
  logic [31:0] s_data;
  logic [1:0]  s_word_count, s_error_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  instruction_encoder #(.ADDRESS_WIDTH(4), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
    .in_immediate(in_immediate),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ready(mem_ready), .error_pulse(error_pulse), .wrapped(wrapped),
    .word_count(word_count), .error_count(error_count)
  );

  // Narrow instance shares all stimulus; used for counter saturation.
  instruction_encoder #(.ADDRESS_WIDTH(2), .COUNT_WIDTH(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
    .in_immediate(in_immediate),
    .mem_write_enable(s_we), .mem_address(s_address), .mem_data(s_data),
    .mem_ready(mem_ready), .error_pulse(s_error_pulse), .wrapped(s_wrapped),
    .word_count(s_word_count), .error_count(s_error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [31:0] imm);
    in_valid     = 1'b1;
    in_opcode    = op;
    in_reg_a     = a;
    in_reg_b     = b;
    in_reg_c     = c;
    in_immediate = imm;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_opcode = '0; in_reg_a = '0; in_reg_b = '0; in_reg_c = '0; in_immediate = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
    chk("rst_addr", {28'd0, mem_address}, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_err", {31'd0, error_pulse}, 32'd0);
    chk("rst_wrapped", {31'd0, wrapped}, 32'd0);
    chk("rst_wcnt", {16'd0, word_count}, 32'd0);
    chk("rst_ecnt", {16'd0, error_count}, 32'd0);
    reset_n = 1'b1;
    tick;

    // ALU word, no backpressure
    mem_ready = 1'b1;
    present(5'd3, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF);
    tick;
    in_valid = 1'b0;
    chk("alu_we", {31'd0, mem_write_enable}, 32'd1);
    chk("alu_data", mem_data, 32'h1844_3FFF);
    chk("alu_addr", {28'd0, mem_address}, 32'd0);
    chk("alu_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("alu_we_off", {31'd0, mem_write_enable}, 32'd0);
    chk("alu_addr_inc", {28'd0, mem_address}, 32'd1);
    chk("alu_wcnt", {16'd0, word_count}, 32'd1);
    chk("alu_in_ready2", {31'd0, in_ready}, 32'd1);

    // Data transfer word with 3 cycles of backpressure
    mem_ready = 1'b0;
    present(5'd2, 5'd4, 5'd5, 5'd0, 32'h0000_7FFF);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_we", {31'd0, mem_write_enable}, 32'd1);
      chk("bp_data", mem_data, 32'h111F_FFCA);
      chk("bp_addr", {28'd0, mem_address}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick;
    end
    mem_ready = 1'b1;
    chk("bp_data4", mem_data, 32'h111F_FFCA);
    chk("bp_we4", {31'd0, mem_write_enable}, 32'd1);
    tick;
    chk("bp_addr_inc", {28'd0, mem_address}, 32'd2);
    chk("bp_we_off", {31'd0, mem_write_enable}, 32'd0);
    chk("bp_wcnt", {16'd0, word_count}, 32'd2);

    // Range rejection, then a boundary value that fits
    present(5'd0, 5'd1, 5'd1, 5'd0, 32'h0000_8000);
    tick;
    in_valid = 1'b0;
    chk("rej_pulse", {31'd0, error_pulse}, 32'd1);
    chk("rej_we", {31'd0, mem_write_enable}, 32'd0);
    chk("rej_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("rej_pulse_off", {31'd0, error_pulse}, 32'd0);
    chk("rej_ecnt", {16'd0, error_count}, 32'd1);
    chk("rej_addr", {28'd0, mem_address}, 32'd2);
    chk("rej_in_ready2", {31'd0, in_ready}, 32'd1);
    present(5'd12, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
    tick;
    in_valid = 1'b0;
    chk("min12_we", {31'd0, mem_write_enable}, 32'd1);
    chk("min12_data", mem_data, 32'h6000_0800);
    chk("min12_err", {31'd0, error_pulse}, 32'd0);
    tick;

    // Control and unformatted words
    present(5'd13, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFC);
    tick;
    in_valid = 1'b0;
    chk("ctl_data", mem_data, 32'h6FFF_FFFC);
    chk("ctl_addr", {28'd0, mem_address}, 32'd3);
    tick;
    present(5'd5, 5'd31, 5'd0, 5'd0, 32'h1234_5678);
    tick;
    in_valid = 1'b0;
    chk("raw_data", mem_data, 32'h2FC0_0000);
    chk("raw_err", {31'd0, error_pulse}, 32'd0);
    chk("raw_we", {31'd0, mem_write_enable}, 32'd1);
    tick;
    chk("raw_addr", {28'd0, mem_address}, 32'd5);
    chk("raw_wcnt", {16'd0, word_count}, 32'd5);

    // Just out of range for 27-bit and 12-bit fields
    present(5'd18, 5'd0, 5'd0, 5'd0, 32'h0400_0000);
    tick;
    in_valid = 1'b0;
    chk("rej27_pulse", {31'd0, error_pulse}, 32'd1);
    tick;
    present(5'd12, 5'd0, 5'd0, 5'd0, 32'h0000_0800);
    tick;
    in_valid = 1'b0;
    chk("rej12_pulse", {31'd0, error_pulse}, 32'd1);
    tick;
    chk("ecnt3", {16'd0, error_count}, 32'd3);

    // Narrow instance: 5 words and 3 errors into 2-bit counters
    chk("sat_wcnt", {30'd0, s_word_count}, 32'd3);
    chk("sat_ecnt", {30'd0, s_error_count}, 32'd3);
    chk("sat_addr", {30'd0, s_address}, 32'd1);
    chk("sat_wrapped", {31'd0, s_wrapped}, 32'd1);

    // Clear, then 17 writes through a 16-word address space
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_addr", {28'd0, mem_address}, 32'd0);
    chk("clr_wcnt", {16'd0, word_count}, 32'd0);
    chk("clr_ecnt", {16'd0, error_count}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      present(5'd7, 5'(i), 5'd0, 5'd0, 32'd0);
      tick;
      in_valid = 1'b0;
      tick;
      if (i == 14) chk("pre_wrap_flag", {31'd0, wrapped}, 32'd0);
    end
    chk("wrap_addr", {28'd0, mem_address}, 32'd0);
    chk("wrap_flag", {31'd0, wrapped}, 32'd1);
    present(5'd7, 5'd16, 5'd0, 5'd0, 32'd0);
    tick;
    in_valid = 1'b0;
    chk("w17_addr", {28'd0, mem_address}, 32'd0);
    chk("w17_we", {31'd0, mem_write_enable}, 32'd1);
    tick;
    chk("w17_wcnt", {16'd0, word_count}, 32'd17);
    chk("w17_wrapped", {31'd0, wrapped}, 32'd1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr2_wrapped", {31'd0, wrapped}, 32'd0);
    chk("clr2_addr", {28'd0, mem_address}, 32'd0);
    chk("clr2_wcnt", {16'd0, word_count}, 32'd0);

    // Asynchronous reset in the middle of a stalled write
    mem_ready = 1'b0;
    present(5'd3, 5'd1, 5'd1, 5'd1, 32'd5);
    tick;
    in_valid = 1'b0;
    chk("ar_we_pre", {31'd0, mem_write_enable}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_we", {31'd0, mem_write_enable}, 32'd0);
    chk("ar_data", mem_data, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    #1 reset_n = 1'b1;
    tick;

    // clear together with in_valid: nothing accepted
    mem_ready = 1'b1;
    clear = 1'b1;
    present(5'd3, 5'd2, 5'd2, 5'd2, 32'd1);
    #1;
    chk("cv_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("cv_we", {31'd0, mem_write_enable}, 32'd0);
    chk("cv_err", {31'd0, error_pulse}, 32'd0);

    // clear abandons a pending write
    mem_ready = 1'b0;
    present(5'd3, 5'd2, 5'd2, 5'd2, 32'd1);
    tick;
    in_valid = 1'b0;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("cw_we", {31'd0, mem_write_enable}, 32'd0);
    chk("cw_wcnt", {16'd0, word_count}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields (opcode, register indices, 32-bit signed immediate) into 32-bit instruction words and writes them sequentially into the processor's instruction memory. It is the exact inverse of the processor's immediate extender: it places each immediate in the field that extender reads and checks that the value survives sign-extension unchanged. It sits between the program loader front end and the instruction-memory write port.

## Interface
- ADDRESS_WIDTH, 8: instruction-memory word-address width; the address counter wraps mod 2^ADDRESS_WIDTH.
- COUNT_WIDTH, 16: width of the saturating word and error counters.
- clock  in  1  the only clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of the address, counters, sticky flag and FSM.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  5  becomes word[31:27].
- in_reg_a, in_reg_b, in_reg_c  in  5 each  register indices.
- in_immediate  in  32  signed immediate.
- mem_write_enable  out  1  write request.
- mem_address  out  ADDRESS_WIDTH  word address.
- mem_data  out  32  encoded word.
- mem_ready  in  1  memory accepts the write this cycle.
- error_pulse  out  1  one-cycle pulse: immediate out of range, bundle dropped.
- wrapped  out  1  sticky; set when the address wraps from max to 0.
- word_count  out  COUNT_WIDTH  words written, saturating.
- error_count  out  COUNT_WIDTH  bundles rejected, saturating.

## Operation
- Formats, by opcode:
  - opcode 0 or 2 (data transfer): [26:22]=reg_a, [21:6]=imm[15:0], [5:1]=reg_b, [0]=0. Range check: signed 16-bit.
  - opcode 3 or 12 (arithmetic/logical): [26:22]=a, [21:17]=b, [16:12]=c, [11:0]=imm[11:0]. Range check: signed 12-bit.
  - opcode 13 or 18 (control transfer): [26:0]=imm[26:0]. Register inputs are ignored. Range check: signed 27-bit.
  - All other opcodes: [26:22]=a, [21:17]=b, [16:12]=c, [11:0]=0. The immediate is ignored and never flags an error.
- Range check: for an N-bit field, in_immediate[31:N-1] must be all-0 or all-1. If not, the bundle is rejected.
- FSM states:
  - IDLE: in_ready=1. On in_valid, the bundle is accepted. In-range goes to WRITE with mem_data latched; out-of-range goes to ERROR.
  - WRITE: mem_write_enable=1; mem_address and mem_data are held stable. On mem_ready: mem_address increments, word_count increments, and the FSM goes to IDLE.
  - ERROR: error_pulse=1 for exactly one cycle, error_count increments, then the FSM goes to IDLE. No memory write occurs.
- Address wrap: max+1 goes to 0, and wrapped is set. Writing continues after the wrap; nothing blocks.
- Counters saturate at all-ones.
- clear has priority over all other events in the same cycle:
  - FSM goes to IDLE, and any pending write is abandoned (mem_write_enable=0 next cycle).
  - mem_address, word_count, error_count and wrapped go to 0.
  - A bundle presented while clear=1 is not accepted.

## Timing
- Reset values: FSM in IDLE, in_ready=1, mem_write_enable=0, mem_address=0, mem_data=0, error_pulse=0, wrapped=0, both counters 0.
- Reset is asynchronous. Asserting it mid-WRITE drops mem_write_enable immediately; the write is lost.
- in_ready is combinational: state==IDLE and not clear.
- Accept at cycle T puts the write on the port at T+1.
- If mem_ready=1 at T+1, the address increments at T+2 and in_ready=1 at T+2.
- Peak throughput is one word per two cycles.
- Rejection: error_pulse at T+1, in_ready at T+2.
- mem_data, mem_address and mem_write_enable are registered outputs. They must not change while WRITE waits on mem_ready.
- mem_ready outside WRITE is ignored.

## Test plan
- ALU word, no backpressure: opcode 3, a=1, b=2, c=3, imm=0xFFFFFFFF -> mem_data=0x18443FFF at address 0 one cycle after accept; word_count=1.
- Data transfer word with 3-cycle backpressure: opcode 2, a=4, b=5, imm=0x00007FFF, mem_ready low 3 cycles -> mem_data=0x111FFFCA held 4 cycles, then address 1; in_ready low throughout.
- Range rejection: opcode 0, imm=0x00008000 -> one-cycle error_pulse, no mem_write_enable, error_count=1, address unchanged. Then opcode 12, imm=0xFFFFF800 -> accepted.
- Control and unformatted words: opcode 13, imm=0xFFFFFFFC -> 0x6FFFFFFC. Opcode 5, a=31, imm=0x12345678 -> 0x2FC00000, no error.
- Wrap, ADDRESS_WIDTH=4: 17 valid writes -> 17th at address 0, wrapped=1, word_count=17. clear -> all zero, wrapped=0.
- Async reset mid-WRITE, and clear coinciding with in_valid: reset -> outputs at reset values without a clock edge. clear + in_valid -> bundle not accepted, no write next cycle.
